instr_fetch_stage: RTL and testbench



---
 rtl/instr_fetch_stage.sv | 175 +++++++++++++++++
 tb/tb_instr_fetch_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage
//
// Front end of the RV32I core. Owns the program counter, fetches one 32-bit
// instruction at a time from instruction memory over a req/ack handshake and
// hands it to decode over a valid/ready handshake. A redirect from downstream
// reloads the PC and squashes whatever is in flight or buffered.
//
// Parameters:
//   RESET_PC   - PC loaded on reset and first fetch address
//   NOP_INSTR  - value shown on if_instr when nothing is buffered
//
// Ports:
//   clk             in   1   rising-edge clock
//   reset           in   1   synchronous, active-high reset
//   imem_req        out  1   fetch request, held with imem_addr until imem_ack
//   imem_addr       out  32  word-aligned fetch address
//   imem_ack        in   1   memory response strobe, one cycle per request
//   imem_rdata      in   32  instruction word, valid with imem_ack
//   if_valid        out  1   if_instr/if_pc hold a valid instruction
//   if_ready        in   1   decode accepts the instruction this cycle
//   if_instr        out  32  fetched instruction
//   if_pc           out  32  address of if_instr
//   redirect_valid  in   1   load new PC and squash the current path
//   redirect_pc     in   32  redirect target, low two bits forced to zero
// ---------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    // FETCH : request outstanding (or about to be issued right after reset)
    // VALID : an instruction is buffered for decode, no request outstanding
    // DROP  : a request on a squashed path is still outstanding; its response
    //         must be swallowed before the new path can be fetched
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] addr_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] ifpc_nxt;
    logic        req_nxt;
    logic [31:0] redirect_target;
    logic        ack_ok;

    // The redirect target is always word aligned; the low bits from
    // downstream are simply discarded.
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    // An ack only means something while a request is actually on the bus.
    // Acks in VALID or in the idle cycle after reset are ignored.
    assign ack_ok = imem_ack && imem_req && (state != VALID);

    // Decode owns the handshake: the buffered instruction is valid exactly
    // while we sit in VALID, so if_valid is a pure state decode.
    assign if_valid = (state == VALID);

    // Next-state and next-register logic. Redirect is checked first in every
    // state because it outranks any ack or decode acceptance in that cycle.
    // A redirect coinciding with if_ready in VALID is deliberately not a
    // transfer: decode must not consume in its own redirect cycle.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = if_instr;
        ifpc_nxt  = if_pc;

        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_target;
                    // A request still waiting on memory has to be drained;
                    // if it was acked this cycle its data is just dropped.
                    if (imem_req && !ack_ok) begin
                        state_nxt = DROP;
                    end
                end else if (ack_ok) begin
                    instr_nxt = imem_rdata;
                    ifpc_nxt  = pc;
                    pc_nxt    = pc + 32'd4;
                    state_nxt = VALID;
                end
            end

            VALID: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_target;
                    instr_nxt = NOP_INSTR;
                    state_nxt = FETCH;
                end else if (if_ready) begin
                    instr_nxt = NOP_INSTR;
                    state_nxt = FETCH;
                end
            end

            DROP: begin
                // Later redirects simply overwrite the target; the old
                // request stays on the bus until memory answers it.
                if (redirect_valid) begin
                    pc_nxt = redirect_target;
                end
                if (ack_ok) begin
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = FETCH;
            end
        endcase

        // A request is on the bus in every state except VALID. In DROP the
        // old address is held; in FETCH the bus follows the PC.
        req_nxt = (state_nxt != VALID);
        if (state_nxt == FETCH) begin
            addr_nxt = pc_nxt;
        end else begin
            addr_nxt = imem_addr;
        end
    end

    // All architectural state and all bus outputs are registered here.
    // imem_req is kept as its own register so that it stays low during
    // reset and rises only in the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            if_instr  <= NOP_INSTR;
            if_pc     <= RESET_PC;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            imem_req  <= req_nxt;
            imem_addr <= addr_nxt;
            if_instr  <= instr_nxt;
            if_pc     <= ifpc_nxt;
        end
    end

    // Memory must only answer a request that is actually outstanding.
    imem_ack_protocol: assert property (
        @(posedge clk) disable iff (reset)
        imem_ack |-> (imem_req && (state != VALID))
    );

    // While a request waits for its ack the address must not move.
    imem_addr_stable: assert property (
        @(posedge clk) disable iff (reset)
        (imem_req && !imem_ack) |=> (reset || $stable(imem_addr))
    );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_stage
//
// Directed bench for instr_fetch_stage. Inputs change 1 time unit after the
// rising edge and outputs are sampled at that same point, so every check
// sees the registered state left by the previous edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RST = 32'h8000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int vec_count;
    int err_count;

    instr_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: a fixed scramble of the address so every
    // fetched word is distinct and easy to predict.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'h00A0_0013;
    endfunction

    // Single comparison point: counts the vector and reports a miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then advance to just after the next edge.
    task automatic applyStimulus(input logic rst, input logic ack,
                                 input logic [31:0] rdata, input logic rdy,
                                 input logic redir, input logic [31:0] rpc);
        reset          = rst;
        imem_ack       = ack;
        imem_rdata     = rdata;
        if_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    // Convenience check of the whole output bundle.
    task automatic checkAll(input string tag, input logic req,
                            input logic [31:0] addr, input logic vld,
                            input logic [31:0] instr, input logic [31:0] pcv);
        checkOutput({tag, ".req"},   {31'd0, imem_req}, {31'd0, req});
        checkOutput({tag, ".addr"},  imem_addr, addr);
        checkOutput({tag, ".valid"}, {31'd0, if_valid}, {31'd0, vld});
        checkOutput({tag, ".instr"}, if_instr, instr);
        checkOutput({tag, ".pc"},    if_pc, pcv);
    endtask

    initial begin
        logic [31:0] a;
        vec_count = 0;
        err_count = 0;
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;

        // Reset values, then the idle cycle right after release.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkAll("reset", 0, RST, 0, NOP, RST);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("first_req", 1, RST, 0, NOP, RST);

        // Zero-wait memory, decode always ready: two cycles per instruction.
        for (int i = 0; i < 3; i++) begin
            a = RST + 32'(4 * i);
            checkAll("zw_fetch", 1, a, 0, NOP, (i == 0) ? RST : a - 32'd4);
            applyStimulus(0, 1, memWord(a), 1, 0, 0);
            checkAll("zw_valid", 0, a, 1, memWord(a), a);
            applyStimulus(0, 0, 0, 1, 0, 0);
        end

        // Ack delayed three cycles: request and address stay put.
        for (int i = 0; i < 3; i++) begin
            checkAll("slow_wait", 1, 32'h8000_000C, 0, NOP, 32'h8000_0008);
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
        applyStimulus(0, 1, memWord(32'h8000_000C), 0, 0, 0);
        checkAll("slow_valid", 0, 32'h8000_000C, 1, memWord(32'h8000_000C),
                 32'h8000_000C);

        // Decode stalls for four cycles: buffer held, no new request.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkAll("stall", 0, 32'h8000_000C, 1, memWord(32'h8000_000C),
                     32'h8000_000C);
        end
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkAll("stall_release", 1, 32'h8000_0010, 0, NOP, 32'h8000_000C);

        // Redirect while the fetch of 0x80000010 is pending: drain and drop.
        applyStimulus(0, 0, 0, 0, 1, 32'h8000_0103);
        checkAll("drop_hold1", 1, 32'h8000_0010, 0, NOP, 32'h8000_000C);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("drop_hold2", 1, 32'h8000_0010, 0, NOP, 32'h8000_000C);
        applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        checkAll("drop_done", 1, 32'h8000_0100, 0, NOP, 32'h8000_000C);

        // Redirect coincident with an ack: the returned word is discarded.
        applyStimulus(0, 1, 32'hBAD0_0001, 0, 1, 32'h8000_0200);
        checkAll("redir_ack", 1, 32'h8000_0200, 0, NOP, 32'h8000_000C);
        applyStimulus(0, 1, memWord(32'h8000_0200), 0, 0, 0);
        checkAll("redir_ack_fetch", 0, 32'h8000_0200, 1,
                 memWord(32'h8000_0200), 32'h8000_0200);

        // Redirect together with if_ready in VALID is not a transfer.
        applyStimulus(0, 0, 0, 1, 1, 32'h8000_0300);
        checkAll("redir_valid", 1, 32'h8000_0300, 0, NOP, 32'h8000_0200);

        // Wrap-around of the PC at the top of the address space.
        applyStimulus(0, 1, 32'hBAD0_0002, 0, 1, 32'hFFFF_FFFF);
        checkAll("wrap_req", 1, 32'hFFFF_FFFC, 0, NOP, 32'h8000_0200);
        applyStimulus(0, 1, memWord(32'hFFFF_FFFC), 0, 0, 0);
        checkAll("wrap_v1", 0, 32'hFFFF_FFFC, 1, memWord(32'hFFFF_FFFC),
                 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkAll("wrap_req2", 1, 32'h0000_0000, 0, NOP, 32'hFFFF_FFFC);
        applyStimulus(0, 1, memWord(32'h0000_0000), 0, 0, 0);
        checkAll("wrap_v2", 0, 32'h0000_0000, 1, memWord(32'h0000_0000),
                 32'h0000_0000);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkAll("wrap_next", 1, 32'h0000_0004, 0, NOP, 32'h0000_0000);

        // Reset in the middle of a DROP abandons the request at once.
        applyStimulus(0, 0, 0, 0, 1, 32'h8000_0500);
        checkAll("pre_reset_drop", 1, 32'h0000_0004, 0, NOP, 32'h0000_0000);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkAll("mid_reset", 0, RST, 0, NOP, RST);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkAll("post_reset", 1, RST, 0, NOP, RST);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count,
                 err_count);
        $finish;
    end

endmodule
